// File: rtl/dm_port_arbiter.sv
// Two-requester round-robin arbiter for the single D-mem port, with an
// in-order ID FIFO that steers each memory response back to its requester.
module dm_port_arbiter #(
   parameter int unsigned MAX_OUTSTANDING = 2
) (
   input  logic                                 clk,
   input  logic                                 rst,

   input  logic [63:0]                          r0_req_addr,
   input  logic [63:0]                          r0_req_wdata,
   input  logic [7:0]                           r0_req_wmask,
   input  logic                                 r0_req_wen,
   input  logic                                 r0_req_valid,
   output logic                                 r0_req_ready,
   output logic [63:0]                          r0_resp_rdata,
   output logic                                 r0_resp_valid,

   input  logic [63:0]                          r1_req_addr,
   input  logic [63:0]                          r1_req_wdata,
   input  logic [7:0]                           r1_req_wmask,
   input  logic                                 r1_req_wen,
   input  logic                                 r1_req_valid,
   output logic                                 r1_req_ready,
   output logic [63:0]                          r1_resp_rdata,
   output logic                                 r1_resp_valid,

   output logic [63:0]                          dm_req_addr,
   output logic [63:0]                          dm_req_wdata,
   output logic [7:0]                           dm_req_wmask,
   output logic                                 dm_req_wen,
   output logic                                 dm_req_valid,
   input  logic                                 dm_req_ready,
   input  logic [63:0]                          dm_resp_rdata,
   input  logic                                 dm_resp_valid,

   output logic [$clog2(MAX_OUTSTANDING):0]     arb_outstanding,
   output logic                                 arb_resp_err
);

   localparam int unsigned PTR_W = $clog2(MAX_OUTSTANDING);
   localparam int unsigned CNT_W = PTR_W + 1;

   typedef enum logic {
      ID_R0 = 1'b0,
      ID_R1 = 1'b1
   } req_id_e;

   req_id_e            r_id_fifo [MAX_OUTSTANDING];
   logic [PTR_W-1:0]   r_wr_ptr;
   logic [PTR_W-1:0]   r_rd_ptr;
   logic [CNT_W-1:0]   r_count;
   req_id_e            r_last_grant;
   logic               r_resp_err;

   logic               w_full;
   logic               w_empty;
   logic               w_gnt0;
   logic               w_gnt1;
   req_id_e            w_gnt_id;
   logic               w_accept;
   logic               w_pop;
   req_id_e            w_head;

   assign w_full  = (r_count == CNT_W'(MAX_OUTSTANDING));
   assign w_empty = (r_count == '0);

   // Under contention the requester that did not win last time is granted.
   assign w_gnt0 = !w_full && r0_req_valid && (!r1_req_valid || (r_last_grant == ID_R1));
   assign w_gnt1 = !w_full && r1_req_valid && (!r0_req_valid || (r_last_grant == ID_R0));
   assign w_gnt_id = w_gnt1 ? ID_R1 : ID_R0;

   assign dm_req_valid = !rst && !w_full && (r0_req_valid || r1_req_valid);
   assign r0_req_ready = w_gnt0 && dm_req_ready && !w_full;
   assign r1_req_ready = w_gnt1 && dm_req_ready && !w_full;
   assign w_accept     = dm_req_valid && dm_req_ready;

   always_comb begin
      dm_req_addr  = r0_req_addr;
      dm_req_wdata = r0_req_wdata;
      dm_req_wmask = r0_req_wmask;
      dm_req_wen   = r0_req_wen;
      if (w_gnt1) begin
         dm_req_addr  = r1_req_addr;
         dm_req_wdata = r1_req_wdata;
         dm_req_wmask = r1_req_wmask;
         dm_req_wen   = r1_req_wen;
      end
   end

   assign w_head = r_id_fifo[r_rd_ptr];
   assign w_pop  = dm_resp_valid && !w_empty;

   assign r0_resp_rdata = dm_resp_rdata;
   assign r1_resp_rdata = dm_resp_rdata;
   assign r0_resp_valid = w_pop && (w_head == ID_R0);
   assign r1_resp_valid = w_pop && (w_head == ID_R1);

   assign arb_outstanding = r_count;
   assign arb_resp_err    = r_resp_err;

   // NOTE: ID storage carries no reset; the count and pointers alone decide
   // which entries are live, so stale contents are never observed.
   always_ff @(posedge clk) begin
      if (w_accept) begin
         r_id_fifo[r_wr_ptr] <= w_gnt_id;
      end
   end

   // NOTE: all state updates use non-blocking assignments so every read in
   // this block sees the pre-edge value, matching the combinational logic.
   always_ff @(posedge clk) begin
      if (rst) begin
         r_wr_ptr     <= '0;
         r_rd_ptr     <= '0;
         r_count      <= '0;
         r_last_grant <= ID_R1;
         r_resp_err   <= 1'b0;
      end else begin
         if (w_accept) begin
            r_wr_ptr     <= r_wr_ptr + PTR_W'(1);
            r_last_grant <= w_gnt_id;
         end
         if (w_pop) begin
            r_rd_ptr <= r_rd_ptr + PTR_W'(1);
         end
         if (dm_resp_valid && w_empty) begin
            r_resp_err <= 1'b1;
         end
         r_count <= r_count + CNT_W'(w_accept) - CNT_W'(w_pop);
      end
   end

endmodule

// File: tb/tb_dm_port_arbiter.sv
// Directed test-plan sequences plus randomized traffic, all checked against a
// queue-based reference model of the arbiter's rules.
module tb_dm_port_arbiter;

   localparam int unsigned MAX_OUT = 2;

   logic        clk = 1'b0;
   logic        rst;
   logic [63:0] r0_req_addr, r0_req_wdata, r1_req_addr, r1_req_wdata;
   logic [7:0]  r0_req_wmask, r1_req_wmask;
   logic        r0_req_wen, r0_req_valid, r1_req_wen, r1_req_valid;
   logic        r0_req_ready, r1_req_ready, r0_resp_valid, r1_resp_valid;
   logic [63:0] r0_resp_rdata, r1_resp_rdata;
   logic [63:0] dm_req_addr, dm_req_wdata, dm_resp_rdata;
   logic [7:0]  dm_req_wmask;
   logic        dm_req_wen, dm_req_valid, dm_req_ready, dm_resp_valid;
   logic [$clog2(MAX_OUT):0] arb_outstanding;
   logic        arb_resp_err;

   always #5 clk = ~clk;

   dm_port_arbiter #(.MAX_OUTSTANDING(MAX_OUT)) dut (
      .clk(clk), .rst(rst),
      .r0_req_addr(r0_req_addr), .r0_req_wdata(r0_req_wdata), .r0_req_wmask(r0_req_wmask),
      .r0_req_wen(r0_req_wen), .r0_req_valid(r0_req_valid), .r0_req_ready(r0_req_ready),
      .r0_resp_rdata(r0_resp_rdata), .r0_resp_valid(r0_resp_valid),
      .r1_req_addr(r1_req_addr), .r1_req_wdata(r1_req_wdata), .r1_req_wmask(r1_req_wmask),
      .r1_req_wen(r1_req_wen), .r1_req_valid(r1_req_valid), .r1_req_ready(r1_req_ready),
      .r1_resp_rdata(r1_resp_rdata), .r1_resp_valid(r1_resp_valid),
      .dm_req_addr(dm_req_addr), .dm_req_wdata(dm_req_wdata), .dm_req_wmask(dm_req_wmask),
      .dm_req_wen(dm_req_wen), .dm_req_valid(dm_req_valid), .dm_req_ready(dm_req_ready),
      .dm_resp_rdata(dm_resp_rdata), .dm_resp_valid(dm_resp_valid),
      .arb_outstanding(arb_outstanding), .arb_resp_err(arb_resp_err)
   );

   int n_checks = 0;
   int n_fails  = 0;

   task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_fails++;
         $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", tag, got, exp, $time);
      end
   endtask

   // Reference model: owners of outstanding requests, oldest first.
   int owners[$];
   int last_grant;
   bit err_flag;

   task automatic model_reset();
      owners.delete();
      last_grant = 1;
      err_flag   = 1'b0;
   endtask

   // Drives one cycle of inputs, checks every output, then advances the model.
   task automatic step(input bit s_rst,
                       input bit v0, input logic [63:0] a0, input bit we0,
                       input bit v1, input logic [63:0] a1, input bit we1,
                       input bit dm_rdy, input bit rsp_v, input logic [63:0] rsp_d);
      int g;
      bit full, exp_valid, accept;
      logic [63:0] exp_addr, exp_wdata;
      logic [7:0]  exp_wmask;
      bit exp_wen, exp_rv0, exp_rv1;

      @(negedge clk);
      rst = s_rst;
      r0_req_valid = v0; r0_req_addr = a0; r0_req_wen = we0;
      r0_req_wdata = {$urandom, $urandom}; r0_req_wmask = 8'($urandom);
      r1_req_valid = v1; r1_req_addr = a1; r1_req_wen = we1;
      r1_req_wdata = {$urandom, $urandom}; r1_req_wmask = 8'($urandom);
      dm_req_ready = dm_rdy; dm_resp_valid = rsp_v; dm_resp_rdata = rsp_d;
      #1;

      full = (owners.size() == MAX_OUT);
      if (full)          g = -1;
      else if (v0 && v1) g = (last_grant == 0) ? 1 : 0;
      else if (v0)       g = 0;
      else if (v1)       g = 1;
      else               g = -1;

      exp_valid = !s_rst && !full && (v0 || v1);
      exp_addr  = (g == 1) ? a1 : a0;
      exp_wdata = (g == 1) ? r1_req_wdata : r0_req_wdata;
      exp_wmask = (g == 1) ? r1_req_wmask : r0_req_wmask;
      exp_wen   = (g == 1) ? we1 : we0;
      exp_rv0   = rsp_v && owners.size() > 0 && owners[0] == 0;
      exp_rv1   = rsp_v && owners.size() > 0 && owners[0] == 1;

      check("dm_req_valid", 64'(dm_req_valid), 64'(exp_valid));
      check("dm_req_addr",  dm_req_addr, exp_addr);
      check("dm_req_wdata", dm_req_wdata, exp_wdata);
      check("dm_req_wmask", 64'(dm_req_wmask), 64'(exp_wmask));
      check("dm_req_wen",   64'(dm_req_wen), 64'(exp_wen));
      check("r0_req_ready", 64'(r0_req_ready), 64'(g == 0 && dm_rdy));
      check("r1_req_ready", 64'(r1_req_ready), 64'(g == 1 && dm_rdy));
      check("r0_resp_valid", 64'(r0_resp_valid), 64'(exp_rv0));
      check("r1_resp_valid", 64'(r1_resp_valid), 64'(exp_rv1));
      if (rsp_v) begin
         check("r0_resp_rdata", r0_resp_rdata, rsp_d);
         check("r1_resp_rdata", r1_resp_rdata, rsp_d);
      end
      check("arb_outstanding", 64'(arb_outstanding), 64'(owners.size()));
      check("arb_resp_err", 64'(arb_resp_err), 64'(err_flag));

      accept = exp_valid && dm_rdy;
      @(posedge clk);
      if (s_rst) begin
         model_reset();
      end else begin
         if (rsp_v) begin
            if (owners.size() > 0) void'(owners.pop_front());
            else                   err_flag = 1'b1;
         end
         if (accept) begin
            owners.push_back(g);
            last_grant = g;
         end
      end
   endtask

   task automatic idle(input bit rsp_v, input logic [63:0] rsp_d);
      step(0, 0, 64'h0, 0, 0, 64'h0, 0, 1, rsp_v, rsp_d);
   endtask

   initial begin
      rst = 1'b1;
      r0_req_valid = 0; r0_req_addr = '0; r0_req_wdata = '0; r0_req_wmask = '0; r0_req_wen = 0;
      r1_req_valid = 0; r1_req_addr = '0; r1_req_wdata = '0; r1_req_wmask = '0; r1_req_wen = 0;
      dm_req_ready = 0; dm_resp_valid = 0; dm_resp_rdata = '0;
      repeat (2) @(posedge clk);
      model_reset();

      // Single requester read, response two cycles later.
      step(0, 1, 64'h1000, 0, 0, 64'h0, 0, 1, 0, 64'h0);
      idle(0, 64'h0);
      idle(1, 64'hDEADBEEF);
      idle(0, 64'h0);

      // Contention: grants alternate, responses one cycle behind.
      for (int i = 0; i < 6; i++)
         step(0, 1, 64'h2000 + 64'(i), 0, 1, 64'h3000 + 64'(i), 1, 1, i > 0, 64'hA0 + 64'(i));
      idle(1, 64'hAF);

      // Backpressure: fill with r1, stall while full, response frees a slot.
      for (int i = 0; i < 3; i++)
         step(0, 0, 64'h0, 0, 1, 64'h4000 + 64'(i), 0, 1, 0, 64'h0);
      step(0, 0, 64'h0, 0, 1, 64'h4003, 0, 1, 1, 64'h11);
      step(0, 0, 64'h0, 0, 1, 64'h4003, 0, 1, 0, 64'h0);

      // Push and pop together at count 1... drain to one r1 first.
      idle(1, 64'h22);
      step(0, 1, 64'h5000, 0, 0, 64'h0, 0, 1, 1, 64'h33);
      idle(1, 64'h44);

      // Withdrawn request, then contention order is unchanged.
      step(0, 1, 64'h6000, 1, 0, 64'h0, 0, 0, 0, 64'h0);
      idle(0, 64'h0);
      step(0, 1, 64'h6100, 0, 1, 64'h6200, 0, 1, 0, 64'h0);
      step(0, 1, 64'h6100, 0, 1, 64'h6200, 0, 1, 1, 64'h55);
      idle(1, 64'h66);

      // Response with nothing outstanding sets the sticky error.
      idle(1, 64'h77);
      idle(0, 64'h0);
      idle(0, 64'h0);

      // Reset while two requests are outstanding.
      step(0, 1, 64'h7000, 0, 0, 64'h0, 0, 1, 0, 64'h0);
      step(0, 0, 64'h0, 0, 1, 64'h7100, 0, 1, 0, 64'h0);
      step(1, 0, 64'h0, 0, 0, 64'h0, 0, 1, 0, 64'h0);
      step(0, 1, 64'h7200, 0, 1, 64'h7300, 0, 1, 1, 64'h88);
      idle(1, 64'h99);

      // Randomized traffic.
      for (int i = 0; i < 3000; i++) begin
         bit rv;
         rv = (owners.size() > 0) ? ($urandom_range(0, 1) == 1) : ($urandom_range(0, 30) == 0);
         step($urandom_range(0, 99) == 0,
              $urandom_range(0, 9) < 6, {$urandom, $urandom}, 1'($urandom),
              $urandom_range(0, 9) < 6, {$urandom, $urandom}, 1'($urandom),
              $urandom_range(0, 9) < 7, rv, {$urandom, $urandom});
      end

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
      $finish;
   end

endmodule
